// File: rtl/mesh_result_checker.sv
// Scans N PE memory words after a settle delay and checks each against a mode-selected pattern.
// Optional MESH_CHECK_ERRMAP_EN adds a per-index mismatch bitmap output (err_map).
module mesh_result_checker #(
  parameter int N             = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 53,
  parameter int RD_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  first_err_vld
`ifdef MESH_CHECK_ERRMAP_EN
  ,
  output logic [N-1:0]          err_map
`endif
);

  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, DRAIN, DONE} state_t;

  state_t                               state_q, state_d;
  logic [31:0]                          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [1:0]                           mode_q, mode_d;
  logic [DATA_WIDTH-1:0]                pattern_q, pattern_d;
  logic [RD_LATENCY-1:0]                dl_vld_q, dl_vld_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] dl_idx_q, dl_idx_d;
  logic [ADDR_WIDTH:0]                  err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]                first_err_idx_q, first_err_idx_d;
  logic                                 first_err_vld_q, first_err_vld_d;
  logic                                 pass_q, pass_d;
`ifdef MESH_CHECK_ERRMAP_EN
  logic [N-1:0]                         err_map_q, err_map_d;
`endif

  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic [DATA_WIDTH-1:0] idx_ext;
  logic [DATA_WIDTH-1:0] exp_dat;
  logic                  mismatch;

  assign rd_en         = (state_q == SCAN);
  assign rd_addr       = rd_en ? addr_q : '0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;
`ifdef MESH_CHECK_ERRMAP_EN
  assign err_map       = err_map_q;
`endif

  // Each issued index rides alongside its read so the compare sees the index the data belongs to.
  always_comb begin
    dl_vld_d    = dl_vld_q;
    dl_idx_d    = dl_idx_q;
    dl_vld_d[0] = rd_en;
    dl_idx_d[0] = rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_idx_d[i] = dl_idx_q[i-1];
    end
  end

  assign cmp_vld = dl_vld_q[RD_LATENCY-1];
  assign cmp_idx = dl_idx_q[RD_LATENCY-1];

  // Expected value is formed modulo 2^DATA_WIDTH, matching truncation of the full-width result.
  always_comb begin
    idx_ext = DATA_WIDTH'(cmp_idx);
    case (mode_q)
      2'd0:    exp_dat = DATA_WIDTH'(N - 1) - idx_ext;
      2'd1:    exp_dat = idx_ext;
      2'd2:    exp_dat = pattern_q;
      default: exp_dat = idx_ext ^ pattern_q;
    endcase
  end

  assign mismatch = cmp_vld && (rd_data != exp_dat);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    mode_d          = mode_q;
    pattern_d       = pattern_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    pass_d          = pass_q;
`ifdef MESH_CHECK_ERRMAP_EN
    err_map_d       = err_map_q;
`endif

    if (mismatch) begin
      if (err_count_q != (ADDR_WIDTH+1)'(N)) err_count_d = err_count_q + 1'b1;
      if (!first_err_vld_q) begin
        first_err_vld_d = 1'b1;
        first_err_idx_d = cmp_idx;
      end
`ifdef MESH_CHECK_ERRMAP_EN
      err_map_d[cmp_idx] = 1'b1;
`endif
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d          = mode;
          pattern_d       = pattern;
          err_count_d     = '0;
          first_err_vld_d = 1'b0;
          pass_d          = 1'b0;
`ifdef MESH_CHECK_ERRMAP_EN
          err_map_d       = '0;
`endif
          cnt_d           = '0;
          addr_d          = '0;
          state_d         = (SETTLE_CYCLES == 0) ? SCAN : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      SCAN: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_WIDTH'(N - 1)) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == 32'(RD_LATENCY - 1)) begin
          cnt_d   = '0;
          // The last compare lands in this cycle, so judge pass on the updated count.
          pass_d  = (err_count_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      mode_q          <= '0;
      pattern_q       <= '0;
      dl_vld_q        <= '0;
      dl_idx_q        <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      pass_q          <= 1'b0;
`ifdef MESH_CHECK_ERRMAP_EN
      err_map_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      mode_q          <= mode_d;
      pattern_q       <= pattern_d;
      dl_vld_q        <= dl_vld_d;
      dl_idx_q        <= dl_idx_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      pass_q          <= pass_d;
`ifdef MESH_CHECK_ERRMAP_EN
      err_map_q       <= err_map_d;
`endif
    end
  end

endmodule

// File: tb/tb_mesh_result_checker.sv
// Directed bench: two checkers (read latency 1 and 3) share stimulus and one memory image.
module tb_mesh_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [5:0] pattern;
  logic [5:0] mem [64];

  logic       rd_en_a, busy_a, done_a, pass_a, first_err_vld_a;
  logic [5:0] rd_addr_a, rd_data_a, first_err_idx_a;
  logic [6:0] err_count_a;
  logic       rd_en_b, busy_b, done_b, pass_b, first_err_vld_b;
  logic [5:0] rd_addr_b, rd_data_b, first_err_idx_b;
  logic [6:0] err_count_b;
`ifdef MESH_CHECK_ERRMAP_EN
  logic [63:0] err_map_a, err_map_b;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mesh_result_checker #(.N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SETTLE_CYCLES(53), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern(pattern),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .first_err_idx(first_err_idx_a), .first_err_vld(first_err_vld_a)
`ifdef MESH_CHECK_ERRMAP_EN
    , .err_map(err_map_a)
`endif
  );

  mesh_result_checker #(.N(64), .ADDR_WIDTH(6), .DATA_WIDTH(6), .SETTLE_CYCLES(53), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern(pattern),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_err_idx(first_err_idx_b), .first_err_vld(first_err_vld_b)
`ifdef MESH_CHECK_ERRMAP_EN
    , .err_map(err_map_b)
`endif
  );

  // Synchronous memory models with 1- and 3-cycle read latency.
  logic [5:0] pipe_a;
  logic [5:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= rd_en_a ? mem[rd_addr_a] : 6'h0;
    pipe_b[0] <= rd_en_b ? mem[rd_addr_b] : 6'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_data_a = pipe_a;
  assign rd_data_b = pipe_b[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int done_cyc_a, done_n_a, rd_n_a, last_rd_a, addr_err_a;
  int done_cyc_b, done_n_b, rd_n_b, last_rd_b, addr_err_b;
  logic busy_after, done_after;

  // Pulses start and watches a fixed 130-cycle window. With poke set, start is also
  // pulsed mid-scan, in the done cycle, and in the cycle after done.
  task automatic run_check(input bit poke);
    done_cyc_a = -1; done_n_a = 0; rd_n_a = 0; last_rd_a = -1; addr_err_a = 0;
    done_cyc_b = -1; done_n_b = 0; rd_n_b = 0; last_rd_b = -1; addr_err_b = 0;
    busy_after = 1'bx; done_after = 1'bx;
    start = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      step();
      start = 1'b0;
      if (rd_en_a) begin
        if (rd_addr_a != 6'(rd_n_a)) addr_err_a++;
        rd_n_a++; last_rd_a = c;
      end else if (rd_addr_a != 6'h0) addr_err_a++;
      if (rd_en_b) begin
        if (rd_addr_b != 6'(rd_n_b)) addr_err_b++;
        rd_n_b++; last_rd_b = c;
      end else if (rd_addr_b != 6'h0) addr_err_b++;
      if (done_a) begin done_n_a++; if (done_cyc_a < 0) done_cyc_a = c; end
      if (done_b) begin done_n_b++; if (done_cyc_b < 0) done_cyc_b = c; end
      if (poke) begin
        if (c == 60) start = 1'b1;
        if (done_a) start = 1'b1;
        if (done_cyc_a > 0 && c == done_cyc_a + 1) begin
          busy_after = busy_a; done_after = done_a; start = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; pattern = 6'h0;
    for (int k = 0; k < 64; k++) mem[k] = 6'(63 - k);
    step(); step(); step();
    chk("rst_busy", busy_a, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err_count", err_count_a, 0);
    chk("rst_first_idx", first_err_idx_a, 0);
    chk("rst_first_vld", first_err_vld_a, 0);
    rst = 1'b0;
    step();

    // Reverse pattern, all words correct.
    mode = 2'd0;
    run_check(0);
    chk("rev_latency_a", done_cyc_a, 119);
    chk("rev_latency_b", done_cyc_b, 121);
    chk("rev_done_pulses", done_n_a, 1);
    chk("rev_rd_count", rd_n_a, 64);
    chk("rev_addr_seq", addr_err_a, 0);
    chk("rev_pass_a", pass_a, 1);
    chk("rev_err_a", err_count_a, 0);
    chk("rev_vld_a", first_err_vld_a, 0);
    chk("rev_pass_b", pass_b, 1);
    chk("rev_idle_busy", busy_a, 0);

    // Identity pattern with two corrupted words.
    mode = 2'd1;
    for (int k = 0; k < 64; k++) mem[k] = 6'(k);
    mem[5] = 6'h00; mem[40] = 6'h3F;
    run_check(0);
    chk("two_err_a", err_count_a, 2);
    chk("two_idx_a", first_err_idx_a, 5);
    chk("two_vld_a", first_err_vld_a, 1);
    chk("two_pass_a", pass_a, 0);
    chk("two_err_b", err_count_b, 2);
    chk("two_idx_b", first_err_idx_b, 5);
`ifdef MESH_CHECK_ERRMAP_EN
    chk("two_map_a", err_map_a, (64'h1 << 5) | (64'h1 << 40));
    chk("two_map_b", err_map_b, (64'h1 << 5) | (64'h1 << 40));
`endif

    // XOR pattern, all correct; latency-3 instance is the one of interest.
    mode = 2'd3; pattern = 6'h2A;
    for (int k = 0; k < 64; k++) mem[k] = 6'(k) ^ 6'h2A;
    run_check(0);
    chk("xor_pass_b", pass_b, 1);
    chk("xor_err_b", err_count_b, 0);
    chk("xor_rd_count_b", rd_n_b, 64);
    chk("xor_addr_seq_b", addr_err_b, 0);
    // Three drain cycles sit between the last read strobe and done.
    chk("xor_drain_gap_b", done_cyc_b - last_rd_b - 1, 3);
    chk("xor_latency_b", done_cyc_b, 121);
    chk("xor_pass_a", pass_a, 1);

    // Starts during scan and in the done cycle are ignored; the next cycle's start is taken.
    mode = 2'd1; pattern = 6'h0;
    for (int k = 0; k < 64; k++) mem[k] = 6'(k);
    run_check(1);
    chk("busy_latency", done_cyc_a, 119);
    chk("busy_done_pulses", done_n_a, 1);
    chk("busy_rd_count", rd_n_a, 64);
    chk("busy_after_done", busy_after, 0);
    chk("busy_no_done_after", done_after, 0);
    chk("busy_restarted", busy_a, 1);
    chk("busy_b_done_pulses", done_n_b, 1);
    begin
      int k;
      k = 0;
      while (!done_a && k < 200) begin step(); k++; end
      // Restart was accepted at cycle 120, so done lands at 239, i.e. 109 after the window.
      chk("restart_latency", k, 109);
      chk("restart_pass", pass_a, 1);
    end

    // Reset in the middle of a failing scan.
    step();
    mode = 2'd2; pattern = 6'h00;
    for (int k = 0; k < 64; k++) mem[k] = 6'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (!(rd_en_a && rd_addr_a == 6'd20) && k < 200) begin step(); k++; end
      chk("mid_reached_idx20", rd_addr_a, 20);
      chk("mid_err_so_far", err_count_a, 19);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_busy", busy_a, 0);
      chk("mid_rd_en", rd_en_a, 0);
      chk("mid_err_count", err_count_a, 0);
      chk("mid_first_vld", first_err_vld_a, 0);
      chk("mid_done", done_a, 0);
      k = 0;
      for (int c = 0; c < 150; c++) begin step(); if (done_a || done_b) k++; end
      chk("mid_no_done", k, 0);
    end

    // Every word wrong after the aborted check.
    run_check(0);
    chk("all_latency", done_cyc_a, 119);
    chk("all_err_a", err_count_a, 64);
    chk("all_idx_a", first_err_idx_a, 0);
    chk("all_vld_a", first_err_vld_a, 1);
    chk("all_pass_a", pass_a, 0);
    chk("all_err_b", err_count_b, 64);
    chk("all_pass_b", pass_b, 0);
`ifdef MESH_CHECK_ERRMAP_EN
    chk("all_map_a", err_map_a, {64{1'b1}});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mesh_result_checker.md
MESH_RESULT_CHECKER -- requirements
Module: mesh_result_checker

Interface
REQ-001 SHALL have parameter N, default 64: number of PE memory words scanned; power of two, 2..1024.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: PE index width; ADDR_WIDTH = log2(N).
REQ-003 SHALL have parameter DATA_WIDTH, default 6: PE memory word width, 1..32.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 53: wait after start before the first read; 0 allowed.
REQ-005 SHALL have parameter RD_LATENCY, default 1: cycles from rd_addr to rd_data; 1..4.
REQ-006 SHALL have ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a check
- mode  in  2  expected pattern: 0 = N-1-k, 1 = k, 2 = pattern, 3 = k XOR pattern
- pattern  in  DATA_WIDTH  operand for modes 2 and 3
- rd_en  out  1  read strobe
- rd_addr  out  ADDR_WIDTH  PE index being read
- rd_data  in  DATA_WIDTH  word returned RD_LATENCY cycles after rd_en
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the check completes
- pass  out  1  1 when the last completed check had zero mismatches
- err_count  out  ADDR_WIDTH+1  mismatch count of the current or last check
- first_err_idx  out  ADDR_WIDTH  lowest mismatching index
- first_err_vld  out  1  first_err_idx is valid

Function
REQ-007 SHALL implement states IDLE, SETTLE, SCAN, DRAIN and DONE.
REQ-008 SHALL accept start only in IDLE; in IDLE with start=1, SHALL latch mode and pattern, clear err_count, first_err_vld and pass, and go to SETTLE, or go straight to SCAN when SETTLE_CYCLES=0.
REQ-009 SHALL ignore start in every state other than IDLE, with no effect on the check in progress.
REQ-010 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, then go to SCAN.
REQ-011 SCAN SHALL assert rd_en for exactly N consecutive cycles, with rd_addr = 0, 1, ..., N-1.
REQ-012 SHALL drive rd_addr to 0 whenever rd_en=0.
REQ-013 After rd_addr=N-1, SHALL go to DRAIN for RD_LATENCY cycles, then to DONE.
REQ-014 SHALL carry each issued index through an RD_LATENCY-deep valid/index delay line and compare rd_data against the expected value at the delayed index.
REQ-015 Expected value SHALL be computed at DATA_WIDTH bits with the upper bits truncated (mode 0 with N=64, DATA_WIDTH=4: index 0 expects 4'hF).
REQ-016 Each mismatch SHALL increment err_count, saturating at N.
REQ-017 The first mismatch of a check SHALL load first_err_idx and set first_err_vld; later mismatches SHALL NOT change them.
REQ-018 DONE SHALL last exactly one cycle: done=1, pass=(err_count==0 including the final compare), then IDLE.
REQ-019 pass, err_count, first_err_idx and first_err_vld SHALL hold their values from DONE until the next accepted start.
REQ-020 busy SHALL be 1 in SETTLE, SCAN, DRAIN and DONE, and 0 in IDLE.
REQ-021 A start asserted in the same cycle as done SHALL be ignored; a start in the following cycle SHALL be accepted.
REQ-022 Total latency from start to done SHALL be SETTLE_CYCLES+N+RD_LATENCY+1 cycles.

Reset
REQ-023 rst=1 SHALL force IDLE, clear all counters and the delay line, and set rd_en=0, rd_addr=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_vld=0.
REQ-024 rst SHALL take priority over start in the same cycle; rst during any state SHALL abort the check with no done pulse.

Configuration
REQ-025 With MESH_CHECK_ERRMAP_EN defined, SHALL add output err_map[N-1:0], cleared at accepted start and reset, bit k set on a mismatch at index k, held after done.
REQ-026 Without MESH_CHECK_ERRMAP_EN, SHALL have no err_map port and no bitmap storage; all other behaviour SHALL be identical.

Verification
REQ-027 Reverse pass: N=64, mode 0, memory[k]=63-k, start -> done at cycle 53+64+1+1=119 after start; pass=1, err_count=0, first_err_vld=0.
REQ-028 Two faults: mode 1, memory[k]=k except indices 5 and 40 -> err_count=2, first_err_idx=5, first_err_vld=1, pass=0; with MESH_CHECK_ERRMAP_EN, err_map bits 5 and 40 set.
REQ-029 Latency sweep: RD_LATENCY=3, mode 3, pattern=6'h2A, all words correct -> pass=1; rd_en high for exactly 64 cycles; done 3 cycles after the last rd_en.
REQ-030 Busy start: start pulsed during SCAN and again in the done cycle -> no restart and a single done pulse; start in the next cycle -> new check begins.
REQ-031 Reset mid-check: rst at scan index 20 -> next cycle busy=0, rd_en=0, err_count=0, no done; a new start then completes normally.
REQ-032 All wrong: mode 2, pattern=0, all words 1 -> err_count=64 (saturated at N), first_err_idx=0, pass=0.
